// File: rtl/mmu_itlb_cached_pkg.sv
// Shared definitions for the instruction MMU: FSM states, segment constants,
// cache attribute encoding and uTLB entry field widths.
package mmu_itlb_cached_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_QUERY = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam int TAG_W  = 20;
  localparam int ASID_W = 8;
  localparam int PFN_W  = 20;
  localparam int C_W    = 3;

  localparam logic [31:0]    KSEG0_BASE        = 32'h8000_0000;
  localparam logic [31:0]    KSEG1_BASE        = 32'hA000_0000;
  localparam logic [31:0]    DMAP_MASK         = 32'h1FFF_FFFF;
  localparam logic [C_W-1:0] CACHE_ATTR_CACHED = 3'd3;

  // kseg0 and kseg1 together form the unmapped 0x8000_0000-0xBFFF_FFFF window
  function automatic logic is_direct(input logic [31:0] va);
    return va[31:30] == KSEG0_BASE[31:30];
  endfunction

  function automatic logic is_kseg1(input logic [31:0] va);
    return va[31:29] == KSEG1_BASE[31:29];
  endfunction

endpackage

// File: rtl/mmu_itlb_cached_cam.sv
// utlb_cam: parallel tag+asid compare across all uTLB entries, returning the
// hit vector, the selected pfn/c and the lowest-index invalid slot.
import mmu_itlb_cached_pkg::*;

module utlb_cam #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]             i_vld,
  input  logic [N-1:0][TAG_W-1:0]  i_tag,
  input  logic [N-1:0][ASID_W-1:0] i_asid,
  input  logic [N-1:0][PFN_W-1:0]  i_pfn,
  input  logic [N-1:0][C_W-1:0]    i_c,
  input  logic [TAG_W-1:0]         i_q_tag,
  input  logic [ASID_W-1:0]        i_q_asid,
  output logic                     o_hit,
  output logic [N-1:0]             o_hit_vec,
  output logic [PFN_W-1:0]         o_pfn,
  output logic [C_W-1:0]           o_c,
  output logic                     o_inv_any,
  output logic [IW-1:0]            o_inv_idx
);

  for (genvar g = 0; g < N; g++) begin : g_cmp
    assign o_hit_vec[g] = i_vld[g] && (i_tag[g] == i_q_tag) && (i_asid[g] == i_q_asid);
  end

  assign o_hit = |o_hit_vec;

  // Fills only follow a miss on the same tag+asid, so the hit vector is one-hot
  always_comb begin
    o_pfn = '0;
    o_c   = '0;
    for (int i = 0; i < N; i++) begin
      if (o_hit_vec[i]) begin
        o_pfn = o_pfn | i_pfn[i];
        o_c   = o_c | i_c[i];
      end
    end
  end

  always_comb begin
    o_inv_any = ~&i_vld;
    o_inv_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!i_vld[i]) o_inv_idx = IW'(i);
    end
  end

endmodule

// File: rtl/mmu_itlb_cached.sv
// Instruction-side MMU with a fully-associative uTLB in front of the main TLB.
// Optional macro ITLB_CACHE_ATTR_EN stores the cache attribute and drives uncached.
import mmu_itlb_cached_pkg::*;

module mmu_itlb_cached #(
  parameter int TLBNUM       = 16,
  parameter int UTLB_NUM     = 4,
  parameter int VICTIM_WIDTH = $clog2(UTLB_NUM)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [31:0]               vaddr,
  input  logic [7:0]                asid,
  input  logic                      flush,
  output logic                      ready,
  output logic [31:0]               psyaddr,
  output logic                      uncached,
  output logic                      is_tlb_refill_tlbl,
  output logic                      is_tlb_invalid_tlbl,
  output logic [18:0]               s_vpn,
  output logic                      s_odd,
  output logic [7:0]                s_asid,
  input  logic                      s_found,
  input  logic [$clog2(TLBNUM)-1:0] s_index,
  input  logic [19:0]               s_pfn,
  input  logic [2:0]                s_c,
  input  logic                      s_d,
  input  logic                      s_v
);

  state_e                              r_state;
  logic [UTLB_NUM-1:0]                 r_vld;
  logic [UTLB_NUM-1:0][TAG_W-1:0]      r_tag;
  logic [UTLB_NUM-1:0][ASID_W-1:0]     r_asid;
  logic [UTLB_NUM-1:0][PFN_W-1:0]      r_pfn_arr;
  logic [VICTIM_WIDTH-1:0]             r_ptr;
  logic                                r_found;
  logic                                r_v;
  logic [PFN_W-1:0]                    r_pfn;
  logic [UTLB_NUM-1:0][C_W-1:0]        w_c_arr;

  logic                                w_hit;
  logic [UTLB_NUM-1:0]                 w_hit_vec;
  logic [PFN_W-1:0]                    w_cam_pfn;
  logic [C_W-1:0]                      w_cam_c;
  logic                                w_inv_any;
  logic [VICTIM_WIDTH-1:0]             w_inv_idx;
  logic [VICTIM_WIDTH-1:0]             w_victim;
  logic                                w_direct;
  logic                                w_idle_ok;
  logic                                w_resp_ok;
  logic                                w_fill;
  logic                                w_unused;

`ifdef ITLB_CACHE_ATTR_EN
  logic [UTLB_NUM-1:0][C_W-1:0]        r_c_arr;
  logic [C_W-1:0]                      r_c;
  assign w_c_arr  = r_c_arr;
  assign w_unused = ^{s_index, s_d, w_hit_vec};
`else
  assign w_c_arr  = '0;
  assign w_unused = ^{s_index, s_d, w_hit_vec, s_c, w_cam_c};
`endif

  assign s_vpn  = vaddr[31:13];
  assign s_odd  = vaddr[12];
  assign s_asid = asid;

  utlb_cam #(.N(UTLB_NUM), .IW(VICTIM_WIDTH)) u_cam (
    .i_vld     (r_vld),
    .i_tag     (r_tag),
    .i_asid    (r_asid),
    .i_pfn     (r_pfn_arr),
    .i_c       (w_c_arr),
    .i_q_tag   (vaddr[31:12]),
    .i_q_asid  (asid),
    .o_hit     (w_hit),
    .o_hit_vec (w_hit_vec),
    .o_pfn     (w_cam_pfn),
    .o_c       (w_cam_c),
    .o_inv_any (w_inv_any),
    .o_inv_idx (w_inv_idx)
  );

  assign w_direct = is_direct(vaddr);
  assign w_victim = w_inv_any ? w_inv_idx : r_ptr;
  assign w_fill   = (r_state == ST_QUERY) && s_found && s_v && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_vld   <= '0;
      r_ptr   <= '0;
      r_found <= 1'b0;
      r_v     <= 1'b0;
      r_pfn   <= '0;
`ifdef ITLB_CACHE_ATTR_EN
      r_c     <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE:  if (en && !w_direct && !w_hit) r_state <= ST_QUERY;
        ST_QUERY: begin
          r_found <= s_found;
          r_v     <= s_v;
          r_pfn   <= s_pfn;
`ifdef ITLB_CACHE_ATTR_EN
          r_c     <= s_c;
`endif
          r_state <= flush ? ST_IDLE : ST_RESP;
        end
        default:  r_state <= ST_IDLE;
      endcase
      if (w_fill) begin
        r_vld[w_victim]     <= 1'b1;
        r_tag[w_victim]     <= vaddr[31:12];
        r_asid[w_victim]    <= asid;
        r_pfn_arr[w_victim] <= s_pfn;
`ifdef ITLB_CACHE_ATTR_EN
        r_c_arr[w_victim]   <= s_c;
`endif
        // pointer only moves when every slot was already occupied
        if (!w_inv_any)
          r_ptr <= (r_ptr == VICTIM_WIDTH'(UTLB_NUM - 1)) ? '0 : r_ptr + VICTIM_WIDTH'(1);
      end
      if (flush) r_vld <= '0;
    end
  end

  assign w_idle_ok = !rst && (r_state == ST_IDLE) && en && (w_direct || w_hit);
  assign w_resp_ok = !rst && (r_state == ST_RESP) && en && !flush;

  assign ready               = w_idle_ok || w_resp_ok;
  assign is_tlb_refill_tlbl  = w_resp_ok && !r_found;
  assign is_tlb_invalid_tlbl = w_resp_ok && r_found && !r_v;

  always_comb begin
    psyaddr = '0;
    if (w_idle_ok)
      psyaddr = w_direct ? (vaddr & DMAP_MASK) : {w_cam_pfn, vaddr[11:0]};
    else if (w_resp_ok && r_found && r_v)
      psyaddr = {r_pfn, vaddr[11:0]};
  end

`ifdef ITLB_CACHE_ATTR_EN
  always_comb begin
    uncached = 1'b0;
    if (w_idle_ok)
      uncached = w_direct ? is_kseg1(vaddr) : (w_cam_c != CACHE_ATTR_CACHED);
    else if (w_resp_ok && r_found && r_v)
      uncached = (r_c != CACHE_ATTR_CACHED);
  end
`else
  assign uncached = 1'b0;
`endif

endmodule

// File: doc/mmu_itlb_cached.md
Name: mmu_itlb_cached

Overview:
- Parametrised instruction-side MMU with a fully-associative micro-TLB (uTLB) in front of the shared main TLB search port.
- Sits between the fetch stage and the main TLB.
- kseg0/kseg1 addresses and uTLB hits translate in the same cycle. A uTLB miss stalls fetch, queries the main TLB once, then refills the uTLB or raises TLBL refill/invalid.

Parameters:
- TLBNUM, 16, number of main-TLB entries; sets the s_index width to $clog2(TLBNUM).
- UTLB_NUM, 4, number of uTLB entries; must be ≥2.
- VICTIM_WIDTH, $clog2(UTLB_NUM), width of the round-robin victim pointer.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- en  in  1  fetch request valid; vaddr and asid are held stable while en=1 and ready=0
- vaddr  in  32  fetch virtual address
- asid  in  8  current EntryHi.ASID
- flush  in  1  invalidate all uTLB entries (TLBWI/TLBWR/EntryHi write)
- ready  out  1  translation or exception result valid this cycle
- psyaddr  out  32  physical address; valid when ready=1 and no exception
- uncached  out  1  fetch is uncached (see Optional Feature)
- is_tlb_refill_tlbl  out  1  main-TLB miss
- is_tlb_invalid_tlbl  out  1  main-TLB hit with V=0
- s_vpn  out  19  main-TLB search vpn, vaddr[31:13]
- s_odd  out  1  vaddr[12]
- s_asid  out  8  asid
- s_found  in  1  main-TLB hit
- s_index  in  $clog2(TLBNUM)  main-TLB hit index (unused, reserved)
- s_pfn  in  20  main-TLB pfn
- s_c  in  3  cache attribute
- s_d  in  1  dirty (unused, instruction side)
- s_v  in  1  valid

Behaviour:
- Decision: tied to the "Already decided" line. Single clock clk; rst is synchronous and active-high.
- uTLB entry contents: valid, tag = vaddr[31:12], asid[7:0], pfn[19:0], c[2:0].
- A hit requires valid, a tag match and an asid match.
- Direct-map region: vaddr[31:30]==2'b10.
  - psyaddr = {3'b000, vaddr[28:0]}.
  - ready=1 combinationally when en=1 and the FSM is in IDLE.
  - Never touches the uTLB.
- FSM states are IDLE, QUERY, RESP.
- IDLE:
  - en=1 and direct, or en=1 and uTLB hit: ready=1 and psyaddr = {pfn, vaddr[11:0]}. Stay in IDLE.
  - en=1 and mapped miss: ready=0, go to QUERY.
- QUERY, one cycle:
  - Latch s_found, s_v, s_pfn, s_c. s_* outputs are driven from vaddr/asid in every state.
  - If s_found&s_v: write the entry at the victim slot.
  - Go to RESP.
- RESP, one cycle:
  - found&v: serve from the latched pfn with ready=1.
  - !found: ready=1, is_tlb_refill_tlbl=1.
  - found&!v: ready=1, is_tlb_invalid_tlbl=1.
  - Return to IDLE.
- Miss latency: ready is asserted 2 cycles after the miss cycle.
- Exception outputs are 0 whenever ready=0 or the FSM is in IDLE.
- Victim selection: lowest-index invalid entry if any. Otherwise the round-robin pointer, which advances by 1 on each such fill and wraps from UTLB_NUM-1 to 0.
- An exception never writes the uTLB.
- flush:
  - All valid bits clear on the next edge; the pointer is not reset.
  - If asserted in QUERY or RESP: abort to IDLE with no fill and ready=0.
  - flush wins over a same-cycle fill.
  - A same-cycle IDLE hit is still served (combinational).
- en dropped mid-miss: the FSM still completes QUERY→RESP; the fill happens but ready is masked. This is legal, not an error.
- Reset:
  - FSM in IDLE, all valid bits=0, pointer=0.
  - Outputs: ready=0, both exception flags=0, psyaddr=0, uncached=0.
- Duplicate tags are impossible: a fill only occurs after a miss on the same tag+asid.

Optional Feature:
- Macro: ITLB_CACHE_ATTR_EN.
- Defined:
  - uncached=1 for kseg1 (vaddr[31:29]==3'b101).
  - For mapped pages, uncached=1 when c!=3'd3.
  - kseg0 gives uncached=0.
- Undefined: the c field is not stored in the uTLB, and uncached is tied to 0.

Decomposition:
- Shared header mmu_defs.vh holds:
  - FSM state encodings (IDLE/QUERY/RESP).
  - KSEG0/KSEG1 base constants and the direct-map mask.
  - CACHE_ATTR_CACHED = 3'd3.
  - Entry field widths.
- One sub-module, utlb_cam: UTLB_NUM-way parallel tag+asid compare. Outputs are hit, the one-hot hit vector, the selected pfn/c, and the first-invalid index.

Test Plan:
- Direct map: en=1, vaddr=0xBFC00000 after reset → ready=1 in the same cycle, psyaddr=0x1FC00000, uncached=1 (macro on).
- Miss then hit:
  - Stimulus: vaddr=0x00400010, asid=5, main TLB returns found=1, v=1, pfn=0x12345.
  - Required: ready=0 for 2 cycles, then ready=1 with psyaddr=0x12345010.
  - Follow-up: the next fetch at 0x00400ABC hits in the same cycle.
- Refill exception: found=0 → RESP cycle has ready=1, is_tlb_refill_tlbl=1; the uTLB is unchanged and a re-fetch misses again.
- Invalid exception: found=1, v=0 → is_tlb_invalid_tlbl=1, no fill.
- Replacement:
  - Fill 5 distinct pages with UTLB_NUM=4 → the 5th fill evicts entry 0 (pointer 0→1).
  - Re-fetching the 1st page misses; the 2nd page still hits.
- Flush/ASID:
  - Assert flush during QUERY → the FSM returns to IDLE with no fill, and the next fetch misses.
  - A hit with asid=5 then a fetch with asid=6 on the same vaddr → miss.
